// File: rtl/key_debounce_step.sv
// key_debounce_step: push-button debouncer producing a clean level, press/release strobes and an optional press counter (KEY_PRESS_CNT_EN).
module key_debounce_step #(
    parameter int   CNT_MAX      = 1_000_000,
    parameter logic ACTIVE_LEVEL = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_in,
    output logic        key_out,
    output logic        key_press,
    output logic        key_release,
    output logic [15:0] press_cnt
);
    localparam int CW = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, PRESS_CHK, PRESSED, REL_CHK} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      sync_q;
    logic            key_out_q, key_out_d;
    logic            press_q, press_d;
    logic            release_q, release_d;
    logic            key_s;
    logic            done;

    assign key_s = (sync_q[1] == ACTIVE_LEVEL);
    assign done  = (cnt_q == CW'(CNT_MAX - 1));

    // two-flop synchroniser, idling at the released level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= {2{~ACTIVE_LEVEL}};
        else        sync_q <= {sync_q[0], key_in};
    end

    // state, stability counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            key_out_q <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            key_out_q <= key_out_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // a level change is accepted only after CNT_MAX stable synchronised cycles
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      state_d = key_s ? PRESS_CHK : IDLE;
            PRESS_CHK: state_d = !key_s ? IDLE : (done ? PRESSED : PRESS_CHK);
            PRESSED:   state_d = !key_s ? REL_CHK : PRESSED;
            REL_CHK:   state_d = key_s ? PRESSED : (done ? IDLE : REL_CHK);
            default:   state_d = IDLE;
        endcase
    end

    // counter runs only while checking; any transition (including a bounce) clears it
    always_comb begin
        cnt_d     = (state_d != state_q) ? '0 :
                    ((state_q == PRESS_CHK) || (state_q == REL_CHK)) ? cnt_q + CW'(1) : '0;
        key_out_d = (state_d == PRESSED) || (state_d == REL_CHK);
        press_d   = (state_q == PRESS_CHK) && (state_d == PRESSED);
        release_d = (state_q == REL_CHK) && (state_d == IDLE);
    end

    assign key_out     = key_out_q;
    assign key_press   = press_q;
    assign key_release = release_q;

`ifdef KEY_PRESS_CNT_EN
    logic [15:0] press_cnt_q;

    // counts accepted presses, wrapping naturally at 16 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       press_cnt_q <= 16'h0000;
        else if (press_q) press_cnt_q <= press_cnt_q + 16'd1;
    end

    assign press_cnt = press_cnt_q;
`else
    assign press_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_key_debounce_step.sv
// tb_key_debounce_step: table-driven and directed checks of key_debounce_step with CNT_MAX=4.
module tb_key_debounce_step;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_in;
    logic        key_out;
    logic        key_press;
    logic        key_release;
    logic [15:0] press_cnt;

    int checks = 0;
    int errors = 0;
    int npress = 0;
    int nrel   = 0;

`ifdef KEY_PRESS_CNT_EN
    localparam int EN = 1;
`else
    localparam int EN = 0;
`endif

    typedef struct {
        logic        key;
        logic        out;
        logic        press;
        logic        rel;
        logic [15:0] pc;
    } vec_t;

    vec_t vecs[$];

    key_debounce_step #(.CNT_MAX(4), .ACTIVE_LEVEL(1'b1)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .key_in(key_in),
        .key_out(key_out),
        .key_press(key_press),
        .key_release(key_release),
        .press_cnt(press_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            npress += int'(key_press);
            nrel   += int'(key_release);
        end
    endtask

    function automatic void add(input logic k, input logic o, input logic p, input logic r, input int pc);
        vec_t v;
        v.key = k; v.out = o; v.press = p; v.rel = r; v.pc = 16'(pc);
        vecs.push_back(v);
    endfunction

    initial begin
        // clean press held 20 cycles then release: edges counted from first sampling edge
        for (int i = 0; i < 30; i++)
            add(i < 20, i >= 6 && i < 26, i == 6, i == 26, EN * (1 + int'(i >= 7)));
        // press bounce 1,1,1,0 then 1 x12; release bounce 0,0,1 then 0 held
        for (int i = 0; i < 31; i++)
            add((i < 3) || (i >= 4 && i < 16) || (i == 18), i >= 10 && i < 25, i == 10, i == 25,
                EN * (2 + int'(i >= 11)));

        rst_n  = 1'b0;
        key_in = 1'b1;
        cyc(3);
        chk("rst_key_out", 32'(key_out), 0);
        chk("rst_key_press", 32'(key_press), 0);
        chk("rst_key_release", 32'(key_release), 0);
        chk("rst_press_cnt", 32'(press_cnt), 0);

        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cyc(1);
            chk($sformatf("post_rst_press_%0d", k), 32'(key_press), 32'(k == 6));
            chk($sformatf("post_rst_out_%0d", k), 32'(key_out), 32'(k >= 6));
        end
        chk("post_rst_pc", 32'(press_cnt), 32'(EN));
        key_in = 1'b0;
        cyc(10);
        chk("post_rst_released", 32'(key_out), 0);

        for (int i = 0; i < vecs.size(); i++) begin
            key_in = vecs[i].key;
            cyc(1);
            chk($sformatf("vec%0d_outs", i), {29'd0, key_out, key_press, key_release},
                {29'd0, vecs[i].out, vecs[i].press, vecs[i].rel});
            chk($sformatf("vec%0d_pc", i), 32'(press_cnt), 32'(vecs[i].pc));
        end

        npress = 0;
        key_in = 1'b1;
        cyc(1);
        key_in = 1'b0;
        cyc(10);
        chk("glitch_npress", 32'(npress), 0);
        chk("glitch_out", 32'(key_out), 0);
        chk("glitch_pc", 32'(press_cnt), 32'(3 * EN));

        nrel   = 0;
        key_in = 1'b1;
        cyc(10);
        chk("mid_pressed", 32'(key_out), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out", 32'(key_out), 0);
        chk("mid_rst_release", 32'(key_release), 0);
        chk("mid_rst_pc", 32'(press_cnt), 0);
        key_in = 1'b0;
        @(negedge clk);
        chk("mid_rst_no_rel", 32'(nrel + int'(key_release)), 0);
        rst_n  = 1'b1;
        npress = 0;
        nrel   = 0;
        key_in = 1'b1;
        cyc(10);
        chk("after_rst_npress", 32'(npress), 1);
        chk("after_rst_out", 32'(key_out), 1);
        chk("after_rst_pc", 32'(press_cnt), 32'(EN));
        key_in = 1'b0;
        cyc(10);
        chk("after_rst_nrel", 32'(nrel), 1);
        chk("after_rst_released", 32'(key_out), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
